// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready pipeline-stage register with data hold,
// control zeroing on bubble/flush, and a saturating back-pressure counter.
// Build option: define PIPE_SKID_EN for the 2-entry skid buffer with a
// registered up_ready; leave it undefined for the single-entry stage whose
// up_ready is combinational.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    input  logic [CTRL_W-1:0] up_ctrl,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data,
    output logic [CTRL_W-1:0] dn_ctrl,
    output logic [1:0]        occupancy,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Encoding equals the number of held entries.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    logic [DATA_W-1:0] m_data;
    logic [CTRL_W-1:0] m_ctrl;
    logic [CNT_W-1:0]  cnt_q;
    logic              accept;
    logic              retire;

    assign dn_valid  = (state != EMPTY);
    assign dn_data   = m_data;
    // m_ctrl is cleared on every transition into EMPTY, so it is already 0 on a bubble.
    assign dn_ctrl   = m_ctrl;
    assign occupancy = 2'(state);
    assign stall_cnt = cnt_q;
    assign accept    = up_valid & up_ready;
    assign retire    = dn_valid & dn_ready;

`ifdef PIPE_SKID_EN
    logic [DATA_W-1:0] s_data;
    logic [CTRL_W-1:0] s_ctrl;
    logic              up_ready_q;

    assign up_ready = up_ready_q;

    // Two-entry elastic state machine: main register M plus skid register S.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= EMPTY;
            m_data     <= '0;
            m_ctrl     <= '0;
            s_data     <= '0;
            s_ctrl     <= '0;
            up_ready_q <= 1'b1;
        end else if (flush) begin
            state      <= EMPTY;
            m_ctrl     <= '0;
            s_ctrl     <= '0;
            up_ready_q <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        m_data <= up_data;
                        m_ctrl <= up_ctrl;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (accept && retire) begin
                        m_data <= up_data;
                        m_ctrl <= up_ctrl;
                    end else if (accept) begin
                        s_data     <= up_data;
                        s_ctrl     <= up_ctrl;
                        state      <= FULL;
                        up_ready_q <= 1'b0;
                    end else if (retire) begin
                        m_ctrl <= '0;
                        state  <= EMPTY;
                    end
                end
                FULL: begin
                    if (retire) begin
                        m_data     <= s_data;
                        m_ctrl     <= s_ctrl;
                        state      <= ONE;
                        up_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    m_ctrl     <= '0;
                    up_ready_q <= 1'b1;
                end
            endcase
        end
    end
`else
    // Single-entry stage: ready passes straight through when the output drains.
    assign up_ready = !dn_valid | dn_ready;

    // Single-entry elastic state machine; FULL is never entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= EMPTY;
            m_data <= '0;
            m_ctrl <= '0;
        end else if (flush) begin
            state  <= EMPTY;
            m_ctrl <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        m_data <= up_data;
                        m_ctrl <= up_ctrl;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (accept) begin
                        m_data <= up_data;
                        m_ctrl <= up_ctrl;
                    end else if (retire) begin
                        m_ctrl <= '0;
                        state  <= EMPTY;
                    end
                end
                default: begin
                    state  <= EMPTY;
                    m_ctrl <= '0;
                end
            endcase
        end
    end
`endif

    // Saturating back-pressure counter; clear beats increment, flush is ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (dn_valid && !dn_ready && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg (works with and without PIPE_SKID_EN).
module tb_pipe_stage_reg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 16;
    localparam int unsigned CNT_W  = 4;

`ifdef PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              up_valid;
    logic              up_ready;
    logic [DATA_W-1:0] up_data;
    logic [CTRL_W-1:0] up_ctrl;
    logic              dn_valid;
    logic              dn_ready;
    logic [DATA_W-1:0] dn_data;
    logic [CTRL_W-1:0] dn_ctrl;
    logic [1:0]        occupancy;
    logic              cnt_clr;
    logic [CNT_W-1:0]  stall_cnt;

    int errors = 0;
    int checks = 0;

    pipe_stage_reg #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .up_valid (up_valid),
        .up_ready (up_ready),
        .up_data  (up_data),
        .up_ctrl  (up_ctrl),
        .dn_valid (dn_valid),
        .dn_ready (dn_ready),
        .dn_data  (dn_data),
        .dn_ctrl  (dn_ctrl),
        .occupancy(occupancy),
        .cnt_clr  (cnt_clr),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [31:0] ed,
                           input logic [15:0] ec, input logic [1:0] eo, input logic er);
        chk({tag, ".dn_valid"},  32'(dn_valid),  32'(ev));
        chk({tag, ".dn_data"},   32'(dn_data),   ed);
        chk({tag, ".dn_ctrl"},   32'(dn_ctrl),   32'(ec));
        chk({tag, ".occupancy"}, 32'(occupancy), 32'(eo));
        chk({tag, ".up_ready"},  32'(up_ready),  32'(er));
    endtask

    initial begin
        rst      = 1'b0;
        flush    = 1'b0;
        up_valid = 1'b0;
        up_data  = '0;
        up_ctrl  = '0;
        dn_ready = 1'b0;
        cnt_clr  = 1'b0;
        #1;
        chk_out("reset", 1'b0, 32'h0, 16'h0, 2'd0, 1'b1);
        chk("reset.stall_cnt", 32'(stall_cnt), 32'd0);
        #16 rst = 1'b1;

        // Streaming: one beat per cycle, one-cycle latency
        dn_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            up_valid = 1'b1;
            up_data  = 32'(i);
            up_ctrl  = 16'(32'h100 + i);
            tick();
            chk_out($sformatf("stream%0d", i), 1'b1, 32'(i), 16'(32'h100 + i), 2'd1, 1'b1);
        end
        up_valid = 1'b0;
        tick();
        chk_out("stream_end", 1'b0, 32'h8, 16'h0, 2'd0, 1'b1);
        chk("stream.stall_cnt", 32'(stall_cnt), 32'd0);

        // Back-pressure with 0xA, 0xB, 0xC
        dn_ready = 1'b0;
        up_valid = 1'b1;
        up_data  = 32'hA;
        up_ctrl  = 16'hA;
        tick();
        chk_out("bp_a", 1'b1, 32'hA, 16'hA, 2'd1, SKID);
        up_data = 32'hB;
        up_ctrl = 16'hB;
        tick();
        chk_out("bp_b", 1'b1, 32'hA, 16'hA, SKID ? 2'd2 : 2'd1, 1'b0);
`ifdef PIPE_SKID_EN
        up_data = 32'hC;
        up_ctrl = 16'hC;
`endif
        tick();
        tick();
        chk("bp.stall_cnt", 32'(stall_cnt), 32'd3);
        chk_out("bp_hold", 1'b1, 32'hA, 16'hA, SKID ? 2'd2 : 2'd1, 1'b0);
        dn_ready = 1'b1;
        #1;
`ifndef PIPE_SKID_EN
        chk("bp_ready_comb", 32'(up_ready), 32'd1);
`endif
        tick();
        chk_out("bp_out_b", 1'b1, 32'hB, 16'hB, 2'd1, 1'b1);
`ifndef PIPE_SKID_EN
        up_data = 32'hC;
        up_ctrl = 16'hC;
`endif
        tick();
        chk_out("bp_out_c", 1'b1, 32'hC, 16'hC, 2'd1, 1'b1);
        up_valid = 1'b0;
        tick();
        chk_out("bp_drain", 1'b0, 32'hC, 16'h0, 2'd0, 1'b1);

        // Flush with a beat offered
        dn_ready = 1'b0;
        up_valid = 1'b1;
        up_data  = 32'hD;
        up_ctrl  = 16'hD;
        tick();
`ifdef PIPE_SKID_EN
        up_data = 32'hE;
        up_ctrl = 16'hE;
        tick();
        chk_out("fl_full", 1'b1, 32'hD, 16'hD, 2'd2, 1'b0);
`endif
        up_data = 32'hF;
        up_ctrl = 16'hF;
        flush   = 1'b1;
        tick();
        chk_out("flush", 1'b0, 32'hD, 16'h0, 2'd0, 1'b1);
        // Beat accepted during flush is discarded
        dn_ready = 1'b1;
        up_data  = 32'h1F;
        up_ctrl  = 16'h1F;
        tick();
        flush    = 1'b0;
        up_valid = 1'b0;
        chk_out("flush_acc", 1'b0, 32'hD, 16'h0, 2'd0, 1'b1);

        // Bubble: control zeroed, data held
        up_valid = 1'b1;
        up_data  = 32'h55;
        up_ctrl  = 16'hFFFF;
        tick();
        chk_out("bub_load", 1'b1, 32'h55, 16'hFFFF, 2'd1, 1'b1);
        up_valid = 1'b0;
        tick();
        chk_out("bubble", 1'b0, 32'h55, 16'h0, 2'd0, 1'b1);

        // Counter saturation and clear priority
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("cnt_clr0", 32'(stall_cnt), 32'd0);
        dn_ready = 1'b0;
        up_valid = 1'b1;
        up_data  = 32'h77;
        up_ctrl  = 16'h7;
        tick();
        up_valid = 1'b0;
        chk("cnt_start", 32'(stall_cnt), 32'd0);
        repeat (14) tick();
        chk("cnt_14", 32'(stall_cnt), 32'd14);
        repeat (6) tick();
        chk("cnt_sat", 32'(stall_cnt), 32'd15);
        cnt_clr = 1'b1;
        tick();
        chk("cnt_clr_wins", 32'(stall_cnt), 32'd0);
        cnt_clr = 1'b0;
        tick();
        chk("cnt_restart", 32'(stall_cnt), 32'd1);

        // Asynchronous reset while holding entries
`ifdef PIPE_SKID_EN
        up_valid = 1'b1;
        up_data  = 32'h88;
        up_ctrl  = 16'h8;
        tick();
        up_valid = 1'b0;
`endif
        chk_out("pre_rst", 1'b1, 32'h77, 16'h7, SKID ? 2'd2 : 2'd1, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 32'h0, 16'h0, 2'd0, 1'b1);
        chk("async_rst.stall_cnt", 32'(stall_cnt), 32'd0);
        #3 rst = 1'b1;
        tick();
        chk_out("post_rst", 1'b0, 32'h0, 16'h0, 2'd0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
